fifo_fwft_out: RTL and testbench

First-word-fall-through output stage for the synchronous FIFO, directly downstream of the read-address controller and the storage array. It drives the read request into the read controller and captures the memory's registered read data into a two-entry output buffer. It presents that data to the consumer through a valid/ready handshake. Full throughput (one word per cycle) is sustained despite the memory's one-cycle read latency.

---
 rtl/fifo_fwft_out_pkg.sv | 15 +
 rtl/fifo_fwft_out.sv | 102 ++++++++++
 tb/tb_fifo_fwft_out.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_out_pkg.sv
// Shared constants and helpers for the FWFT output stage of the synchronous FIFO.
package fifo_fwft_out_pkg;

  // Default word width of the FIFO data path.
  localparam int FIFO_DATA_WIDTH = 8;

  // Slots still committed after this cycle: buffered + in flight - popped.
  // The caller guarantees pop implies occ != 0, so this never underflows.
  function automatic logic [2:0] slots_after(input logic [1:0] occ,
                                             input logic       inflight,
                                             input logic       pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_fwft_out.sv
// FWFT output stage: issues read requests on a two-slot credit, absorbs the
// memory's one-cycle read latency in a head/skid pair, and presents the head
// word on a valid/ready interface at one word per cycle.
module fifo_fwft_out
  import fifo_fwft_out_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  occ, occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] skid;
  logic                  fetch, pop, arrive;
  logic                  ld_head_rd, ld_head_skid, ld_skid;

  // Credit check and slot steering; rd_ready includes this cycle's pop so a
  // drained slot is refilled without a bubble.
  always_comb begin
    occ_nxt      = occ;
    ld_head_rd   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    pop          = dout_valid & dout_ready;
    arrive       = inflight;
    rd_ready     = !reset && (slots_after(occ, inflight, pop) < 3'd2);
    fetch        = rd_ready & !rd_empty;
    case (occ)
      EMPTY: begin
        if (arrive) begin
          occ_nxt    = ONE;
          ld_head_rd = 1'b1;
        end
      end
      ONE: begin
        if (arrive && pop) begin
          ld_head_rd = 1'b1;
        end else if (arrive) begin
          occ_nxt = TWO;
          ld_skid = 1'b1;
        end else if (pop) begin
          occ_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          ld_head_skid = 1'b1;
          if (arrive) ld_skid = 1'b1;
          else        occ_nxt = ONE;
        end
      end
      default: occ_nxt = EMPTY;
    endcase
  end

  // Occupancy, in-flight marker and registered valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ        <= EMPTY;
      inflight   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      occ        <= occ_nxt;
      inflight   <= fetch;
      dout_valid <= (occ_nxt != EMPTY);
    end
  end

  // Head and skid data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      skid <= '0;
    end else begin
      if (ld_head_rd)        dout <= rd_data;
      else if (ld_head_skid) dout <= skid;
      if (ld_skid)           skid <= rd_data;
    end
  end

  // An arrival into a full buffer with no pop would lose a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(occ == TWO && inflight && !pop));

  a_credit: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: tb/tb_fifo_fwft_out.sv
// Bench for fifo_fwft_out: a FIFO source model feeds the DUT, words are queued
// as expected when written, and a monitor checks every pop against the queue.
module tb_fifo_fwft_out;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_empty;
  logic [DW-1:0] rd_data = '0;
  logic          rd_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [4096];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] exp_q [$];

  int cyc = 0;
  int pop_cnt = 0;
  int fetch_cnt = 0;
  int last_pop_cyc = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  fifo_fwft_out #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_empty   (rd_empty),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  assign rd_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) cyc <= cyc + 1;

  // Read controller + memory: registered read data one cycle after a fetch.
  always @(posedge clk) begin
    if (reset) rd_cnt <= wr_cnt;
    else if (rd_ready && !rd_empty) begin
      rd_data <= mem[rd_cnt % 4096];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, hold stability and the two-slot credit bound.
  always @(negedge clk) begin
    if (reset) begin
      fetch_cnt = pop_cnt;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", 32'(dout), 32'(prev_dout));
      end
      if (rd_ready && !rd_empty) fetch_cnt++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_pop actual=%0h required=none", dout);
        end else begin
          chk("pop_data", 32'(dout), 32'(exp_q.pop_front()));
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      chk("credit_le2", 32'(fetch_cnt - pop_cnt <= 2), 32'd1);
      prev_hold = dout_valid & !dout_ready;
      prev_dout = dout;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] v);
    mem[wr_cnt % 4096] = v;
    exp_q.push_back(v);
    wr_cnt++;
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pop_cnt < target && n < 300) begin
      step();
      n++;
    end
    if (pop_cnt < target) chk(name, 32'(pop_cnt), 32'(target));
  endtask

  initial begin
    int wcyc, c0, base, r0, written;

    // Reset state.
    repeat (3) begin
      step();
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    end
    reset = 1'b0;
    step();

    // Single word 0xA1: fetch in cycle t, dout valid in t+2.
    wr(8'hA1);
    #1;
    chk("first_rd_ready", 32'(rd_ready), 32'd1);
    step();
    chk("first_valid_t1", 32'(dout_valid), 32'd0);
    step();
    chk("first_valid_t2", 32'(dout_valid), 32'd1);
    chk("first_dout", 32'(dout), 32'hA1);
    step();
    dout_ready = 1'b1;
    wait_pops(1, "first_pop_timeout");
    step();

    // Stream 0x00..0x07 with no bubble after the first word.
    wcyc = cyc;
    base = pop_cnt;
    for (int i = 0; i < 8; i++) wr(8'(i));
    wait_pops(base + 1, "stream_first_timeout");
    c0 = last_pop_cyc;
    chk("stream_latency", 32'(c0 - wcyc), 32'd2);
    wait_pops(base + 8, "stream_timeout");
    chk("stream_gapless", 32'(last_pop_cyc - c0), 32'd7);
    step();

    // Back-pressure: two fetches only, then gapless release.
    dout_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 4; i++) wr(8'(i));
    repeat (6) step();
    chk("bp_fetches", 32'(rd_cnt - r0), 32'd2);
    chk("bp_rd_ready", 32'(rd_ready), 32'd0);
    chk("bp_valid", 32'(dout_valid), 32'd1);
    chk("bp_head", 32'(dout), 32'h00);
    base = pop_cnt;
    dout_ready = 1'b1;
    #1;
    chk("release_rd_ready", 32'(rd_ready), 32'd1);
    wait_pops(base + 1, "release_first_timeout");
    c0 = last_pop_cyc;
    wait_pops(base + 4, "release_timeout");
    chk("release_gapless", 32'(last_pop_cyc - c0), 32'd3);
    step();

    // Random consumer stall and source gaps over 1000 words.
    base = pop_cnt;
    written = 0;
    while (written < 1000) begin
      dout_ready = 1'($urandom_range(0, 1));
      if ((wr_cnt - rd_cnt) < 3 && $urandom_range(0, 3) != 0) begin
        wr(8'((written * 7 + 3) & 8'hFF));
        written++;
      end
      step();
    end
    dout_ready = 1'b1;
    wait_pops(base + 1000, "random_drain_timeout");
    chk("random_count", 32'(pop_cnt - base), 32'd1000);
    chk("random_q_empty", 32'(exp_q.size()), 32'd0);
    step();

    // Drain to empty, valid drops, then a fresh word with 2-cycle latency.
    base = pop_cnt;
    for (int i = 0; i < 3; i++) wr(8'(8'h30 + i));
    wait_pops(base + 3, "drain_timeout");
    chk("drain_valid_low", 32'(dout_valid), 32'd0);
    wcyc = cyc;
    wr(8'h33);
    wait_pops(base + 4, "resume_timeout");
    chk("resume_latency", 32'(last_pop_cyc - wcyc), 32'd2);
    step();

    // Reset with one word buffered and one in flight.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(8'h40 + i));
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_rd_ready", 32'(rd_ready), 32'd0);
    reset = 1'b0;
    dout_ready = 1'b1;
    base = pop_cnt;
    repeat (6) step();
    chk("midrst_no_stale", 32'(pop_cnt), 32'(base));
    wr(8'h5C);
    wait_pops(base + 1, "post_rst_timeout");
    step();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
